store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
- Data-memory write path of the RISC core; the narrowing counterpart of the load-side sign extenders.
- Accepts a 32-bit register value and a store size (byte/half/word) and truncates it to that width.
- Writes it into a word-only, single-port synchronous data memory, using read-modify-write for sub-word stores.
- Sits between the EX/MEM stage and data memory; raises a one-cycle done pulse on completion.

Parameters:
ADDR_W, 10, word-address width of data memory (mem_addr = req_addr[ADDR_W+1:2])
RD_LAT, 1, data-memory read latency in cycles (1..3); mem_rdata is valid RD_LAT cycles after mem_rd_en

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  store request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_addr  in  32  byte address
req_data  in  32  register value to store
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
done  out  1  one-cycle completion pulse
misalign_err  out  1  pulses with done when the request was rejected
trunc_ovf  out  1  pulses with done on lossy truncation (optional feature)
mem_addr  out  ADDR_W  word address
mem_rd_en  out  1  read strobe
mem_rdata  in  32  read data
mem_wr_en  out  1  write strobe
mem_wdata  out  32  merged write word

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset state: FSM to IDLE. req_ready=1; done, misalign_err, trunc_ovf, mem_rd_en, mem_wr_en = 0; mem_addr and mem_wdata = 0.
- Handshake: a request is accepted at an edge with req_valid && req_ready. The unit latches addr, data and size; inputs are don't-care afterwards. req_ready stays low until the FSM returns to IDLE.
- States: IDLE, RD, WAIT, WR, DONE, ERR.
- IDLE -> ERR on accept if:
  - size=11, or
  - size=01 with addr[0]=1, or
  - size=10 with addr[1:0]!=00.
- ERR (one cycle): done=1, misalign_err=1, no memory strobes; next state IDLE.
- IDLE -> WR on accept of an aligned word store (no read).
- IDLE -> RD on accept of an aligned sub-word store.
- RD (one cycle): mem_rd_en=1; mem_addr=latched addr word index.
- WAIT: lasts RD_LAT cycles, counted by a down-counter. mem_rdata is captured on the last WAIT edge; then -> WR.
- WR (one cycle): mem_wr_en=1, with mem_wdata:
  - word: data.
  - half: rdata with lane addr[1]*16 replaced by data[15:0].
  - byte: rdata with lane addr[1:0]*8 replaced by data[7:0].
  - Little-endian; all other bytes unchanged.
- DONE (one cycle): done=1; next state IDLE. req_ready returns high in the cycle after DONE.
- Latency from accept edge to done-high cycle:
  - word: 2 cycles.
  - sub-word: 3+RD_LAT cycles (4 at default).
  - error: 1 cycle.
- Strobes: mem_rd_en and mem_wr_en are never both high, and each is high for exactly one cycle per request.
- Reset mid-operation: abort immediately and return to IDLE. A pending write is not issued if rst is high in the WR cycle.
- req_valid while busy: ignored, no queuing.
- Back-to-back requests: earliest acceptance is the IDLE cycle following DONE or ERR.

Optional Feature:
- Macro: STORE_TRUNC_CHECK_EN.
- With the macro: for byte and half stores, trunc_ovf pulses together with done when req_data[31:W] is not all equal to req_data[W-1] (W=8 or 16), i.e. sign-extending the stored value would not recover the register. Word stores and error cases never set it. The store is still performed.
- Without the macro: the port is present but tied to 0 and no check logic is built.

Decomposition:
- Shared package store_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the FSM state enum;
  - the lane-width constants.
- Sub-module byte_lane_merge: combinational; inputs old word, new data, size, addr[1:0]; output merged word. It is reused by the future store-buffer block.

Test Plan:
- Word store addr=0x0000_0010, data=0xDEAD_BEEF -> no mem_rd_en; mem_wr_en with mem_addr=4 and mem_wdata=0xDEADBEEF one cycle after accept; done the next cycle.
- Byte store addr=0x0000_0006, data=0x0000_00AB, memory word 4'h1 = 0x11223344 -> mem_rd_en at mem_addr=1; mem_wdata=0x11AB3344; done 4 cycles after accept (RD_LAT=1).
- Half store addr=0x0000_0002, data=0x1234_5678, memory = 0xAAAABBBB -> mem_wdata=0x5678BBBB; with STORE_TRUNC_CHECK_EN, trunc_ovf=1. Repeat with data=0xFFFF_8001 -> trunc_ovf=0.
- Misaligned half addr=0x0000_0003; misaligned word addr=0x0000_0002; size=11 -> each gives done=1 and misalign_err=1 one cycle after accept, with no memory strobes.
- Assert rst during WAIT of a byte store -> no mem_wr_en, done stays 0, req_ready=1 on the cycle after reset release; a new word store then completes normally.
- RD_LAT=3 build, back-to-back byte stores to the same word -> the second read returns the first write's data and both bytes persist; req_ready low throughout each operation.

Source files
------------

// File: rtl/store_pkg.sv
// Shared definitions for the store narrowing path: size codes, FSM states,
// lane geometry and request classification helpers.
package store_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int LANE_W    = 8;
   localparam int HALF_W    = 16;
   localparam int WORD_W    = 32;
   localparam int NUM_LANES = WORD_W / LANE_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_WR,
      ST_DONE,
      ST_ERR
   } state_e;

   // Illegal size code or a store not naturally aligned to its width.
   function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      bad = 1'b1;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Narrowing loses information when sign-extension cannot rebuild the register.
   function automatic logic is_lossy(input logic [1:0] size, input logic [WORD_W-1:0] data);
      logic lossy;
      lossy = 1'b0;
      case (size)
         SZ_BYTE: lossy = (data[WORD_W-1:LANE_W] != {(WORD_W-LANE_W){data[LANE_W-1]}});
         SZ_HALF: lossy = (data[WORD_W-1:HALF_W] != {(WORD_W-HALF_W){data[HALF_W-1]}});
         default: lossy = 1'b0;
      endcase
      return lossy;
   endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational little-endian merge of a narrowed store into an existing word.
// Shared with the store-buffer block, so it carries no state.
module byte_lane_merge
   import store_pkg::*;
(
   input  logic [WORD_W-1:0] old_word,
   input  logic [WORD_W-1:0] new_data,
   input  logic [1:0]        size,
   input  logic [1:0]        off,
   output logic [WORD_W-1:0] merged
);

   logic [NUM_LANES-1:0][LANE_W-1:0] old_l;
   logic [NUM_LANES-1:0][LANE_W-1:0] new_l;
   logic [NUM_LANES-1:0][LANE_W-1:0] out_l;

   assign old_l  = old_word;
   assign new_l  = new_data;
   assign merged = out_l;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic              we;
      logic [LANE_W-1:0] src;

      // Narrow stores always source from the low lanes of the register.
      always_comb begin
         we  = 1'b0;
         src = new_l[i];
         case (size)
            SZ_BYTE: begin
               we  = (off == 2'(i));
               src = new_l[0];
            end
            SZ_HALF: begin
               we  = (off[1] == 1'(i / 2));
               src = new_l[i % 2];
            end
            SZ_WORD: we = 1'b1;
            default: we = 1'b0;
         endcase
      end

      assign out_l[i] = we ? src : old_l[i];
   end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: truncates a register to byte/half/word and writes it to
// word-only memory via read-modify-write. Optional lossy-truncation flag: STORE_TRUNC_CHECK_EN.
module store_narrow_unit
   import store_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              done,
   output logic              misalign_err,
   output logic              trunc_ovf,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr_en,
   output logic [31:0]       mem_wdata
);

   localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              accept;
   logic              req_bad;
   logic [31:0]       merged;
   logic              unused_addr_hi;

   assign accept         = req_valid && (state_q == ST_IDLE);
   assign req_bad        = is_bad(req_size, req_addr[1:0]);
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d = req_addr[ADDR_W+1:0];
               data_d = req_data;
               size_d = req_size;
               if (req_bad)                  state_d = ST_ERR;
               else if (req_size == SZ_WORD) state_d = ST_WR;
               else                          state_d = ST_RD;
            end
         end
         ST_RD: begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
         end
         // Read data lands on the final WAIT cycle, RD_LAT cycles after the strobe.
         ST_WAIT: begin
            if (cnt_q == 2'd0) begin
               rdata_d = mem_rdata;
               state_d = ST_WR;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_WR:   state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         size_q  <= SZ_BYTE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         cnt_q   <= cnt_d;
      end
   end

   byte_lane_merge u_merge (
      .old_word (rdata_q),
      .new_data (data_q),
      .size     (size_q),
      .off      (addr_q[1:0]),
      .merged   (merged)
   );

   assign req_ready    = (state_q == ST_IDLE);
   assign done         = (state_q == ST_DONE) || (state_q == ST_ERR);
   assign misalign_err = (state_q == ST_ERR);
   assign mem_rd_en    = (state_q == ST_RD);
   // Reset in the write cycle must suppress the strobe before the edge commits it.
   assign mem_wr_en    = (state_q == ST_WR) && !rst;
   assign mem_addr     = addr_q[ADDR_W+1:2];
   assign mem_wdata    = (state_q == ST_WR) ? merged : '0;

`ifdef STORE_TRUNC_CHECK_EN
   logic trunc_q, trunc_d;

   always_comb begin
      trunc_d = trunc_q;
      if (accept) trunc_d = !req_bad && is_lossy(req_size, req_data);
   end

   always_ff @(posedge clk) begin
      if (rst) trunc_q <= 1'b0;
      else     trunc_q <= trunc_d;
   end

   assign trunc_ovf = (state_q == ST_DONE) && trunc_q;
`else
   assign trunc_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed plus random stores against a
// word-array reference memory with byte-mask arithmetic.
module tb_store_narrow_unit #(
   parameter int RD_LAT = 1
);
   localparam int ADDR_W = 10;
   localparam int NWORDS = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [31:0]       req_addr = '0;
   logic [31:0]       req_data = '0;
   logic [1:0]        req_size = '0;
   logic              done, misalign_err, trunc_ovf;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en, mem_wr_en;
   logic [31:0]       mem_rdata, mem_wdata;

   logic              pl_en = 1'b0;
   logic [ADDR_W-1:0] pl_addr = '0;
   logic [31:0]       pl_data = '0;

   logic [31:0] dmem    [0:(1<<ADDR_W)-1];
   logic [31:0] rpipe   [0:RD_LAT-1];
   logic [31:0] ref_mem [0:NWORDS-1];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_narrow_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .done(done), .misalign_err(misalign_err), .trunc_ovf(trunc_ovf),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
   );

   // Synchronous memory with RD_LAT-deep read pipeline; unstrobed slots carry X.
   always @(posedge clk) begin
      if (pl_en) dmem[pl_addr] <= pl_data;
      else if (mem_wr_en) dmem[mem_addr] <= mem_wdata;
      rpipe[0] <= mem_rd_en ? dmem[mem_addr] : 'x;
      for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign mem_rdata = rpipe[RD_LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sext(input logic [31:0] d, input int nb);
      int sh;
      sh = 32 - 8 * nb;
      return $signed(d << sh) >>> sh;
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      int          nb, lat, exp_lat, rd_cnt, wr_cnt, rd_k, both, rdy_busy;
      logic        exp_err, exp_tr, got_err, got_tr;
      logic [63:0] m;
      logic [31:0] mask, old, exp_wd, got_wd;
      logic [ADDR_W-1:0] wi, got_wa;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      exp_err = (sz == 2'd3) || ((a % nb) != 0);
      wi  = a[ADDR_W+1:2];
      old = ref_mem[wi];
      m   = ((64'd1 << (8 * nb)) - 64'd1) << (8 * a[1:0]);
      mask = m[31:0];
      exp_wd = (old & ~mask) | ((d << (8 * a[1:0])) & mask);
`ifdef STORE_TRUNC_CHECK_EN
      exp_tr = !exp_err && (nb < 4) && (sext(d, nb) != d);
`else
      exp_tr = 1'b0;
`endif
      exp_lat = exp_err ? 1 : (nb == 4) ? 2 : 3 + RD_LAT;
      wait_ready();
      req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
      @(posedge clk);
      lat = 0; rd_cnt = 0; wr_cnt = 0; rd_k = 0; both = 0; rdy_busy = 0;
      got_err = 1'b0; got_tr = 1'b0; got_wd = '0; got_wa = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (mem_rd_en) begin rd_cnt++; rd_k = k; end
         if (mem_wr_en) begin wr_cnt++; got_wd = mem_wdata; got_wa = mem_addr; end
         if (mem_rd_en && mem_wr_en) both++;
         if (req_ready) rdy_busy++;
         if (done) begin
            lat = k; got_err = misalign_err; got_tr = trunc_ovf;
            break;
         end
         // Traffic while busy must be ignored.
         req_valid = 1'($urandom);
         req_addr  = $urandom;
         req_data  = $urandom;
         req_size  = 2'($urandom);
      end
      req_valid = 1'b0;
      chk("latency", lat, exp_lat);
      chk("misalign_err", {31'd0, got_err}, {31'd0, exp_err});
      chk("trunc_ovf", {31'd0, got_tr}, {31'd0, exp_tr});
      chk("rd_count", rd_cnt, (exp_err || nb == 4) ? 0 : 1);
      chk("wr_count", wr_cnt, exp_err ? 0 : 1);
      chk("strobe_overlap", both, 0);
      chk("ready_busy", rdy_busy, 0);
      if (!exp_err) begin
         chk("wdata", got_wd, exp_wd);
         chk("waddr", {22'd0, got_wa}, {22'd0, wi});
         if (nb < 4) chk("rd_cycle", rd_k, 1);
         ref_mem[wi] = exp_wd;
      end
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("ready_after", {31'd0, req_ready}, 32'd1);
   endtask

   // Starts a byte store and asserts reset in cycle abort_k after accept.
   task automatic abort_store(input logic [31:0] a, input int abort_k);
      wait_ready();
      req_valid = 1'b1; req_addr = a; req_data = $urandom; req_size = 2'd0;
      @(posedge clk);
      req_valid = 1'b0;
      for (int k = 1; k < abort_k; k++) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_wr_gate", {31'd0, mem_wr_en}, 32'd0);
      @(negedge clk);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_wr", {31'd0, mem_wr_en}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("release_ready", {31'd0, req_ready}, 32'd1);
      chk("release_done", {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [31:0] v, a, d;
      logic [1:0]  sz;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, misalign_err}, 32'd0);
      chk("rst_trunc", {31'd0, trunc_ovf}, 32'd0);
      chk("rst_rd", {31'd0, mem_rd_en}, 32'd0);
      chk("rst_wr", {31'd0, mem_wr_en}, 32'd0);
      chk("rst_addr", {22'd0, mem_addr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      for (int i = 0; i < NWORDS; i++) begin
         v = (i == 0) ? 32'hAAAABBBB : (i == 1) ? 32'h11223344 : $urandom;
         pl_en = 1'b1; pl_addr = ADDR_W'(i); pl_data = v;
         ref_mem[i] = v;
         @(negedge clk);
      end
      pl_en = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      do_store(32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
      do_store(32'h0000_0006, 32'h0000_00AB, 2'b00);
      do_store(32'h0000_0002, 32'h1234_5678, 2'b01);
      do_store(32'h0000_0002, 32'hFFFF_8001, 2'b01);
      do_store(32'h0000_0003, 32'h0000_1111, 2'b01);
      do_store(32'h0000_0002, 32'h2222_2222, 2'b10);
      do_store(32'h0000_0004, 32'h3333_3333, 2'b11);

      abort_store(32'h0000_000C, 2);
      abort_store(32'h0000_000D, 2 + RD_LAT);
      do_store(32'h0000_0014, 32'h0BAD_F00D, 2'b10);

      do_store(32'h0000_0008, 32'h0000_0011, 2'b00);
      do_store(32'h0000_0009, 32'hFFFF_FF92, 2'b00);
      do_store(32'h0000_000A, 32'h0000_7FFF, 2'b01);

      for (int n = 0; n < 60; n++) begin
         a  = $urandom_range(0, 4 * NWORDS - 1);
         sz = 2'($urandom_range(0, 3));
         d  = $urandom;
         if ($urandom_range(0, 1) == 0) d = sext(d, (sz == 2'd0) ? 1 : 2);
         do_store(a, d, sz);
      end

      @(negedge clk);
      for (int i = 0; i < NWORDS; i++) chk("mem_final", dmem[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
